oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Sprite (OAM) DMA sequencer for the CPU bus.
//  - Snoops CPU writes to $4014, halts the CPU through rdy, then owns the bus.
//  - Copies XFER_LEN bytes from page {val,8'h00} to OAM_DATA_ADDR, read/write alternating.
//  - Sits between the cpu and mem modports of cpu_intf; bus_sel drives the address/data mux.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  CPU write address that triggers DMA
//  OAM_DATA_ADDR  16'h2004  destination address of every DMA write
//  XFER_LEN       256       bytes per transfer (1..256); index is 8 bits
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  cyc_en       in   1   CPU-cycle strobe (syn_clk); one clk wide per CPU cycle
//  cpu_addr     in   16  CPU addr_out
//  cpu_data     in   8   CPU data_out
//  cpu_wen      in   1   CPU write enable
//  mem_rdata    in   8   memory read data (data_in path)
//  rdy          out  1   to CPU rdy; 0 = CPU halted
//  bus_sel      out  1   1 = DMA drives addr/data/ren/wen to memory
//  dma_addr     out  16  DMA bus address
//  dma_wdata    out  8   DMA write data
//  dma_ren      out  1   DMA read strobe
//  dma_wen      out  1   DMA write strobe
//  busy         out  1   1 in any state except IDLE
// BEHAVIOUR
//  - Reset values: rdy=1; bus_sel=0; dma_ren=0; dma_wen=0; busy=0; dma_addr=0; dma_wdata=0.
//  - Reset internals: state=IDLE, idx=0, page=0, get_cyc=0.
//  - State, idx, page and data latch change only on clk edges with cyc_en=1.
//  - get_cyc toggles on every cyc_en from reset; get_cyc=1 marks a get (read-eligible) cycle.
//  - FSM states: IDLE, HALT, ALIGN, READ, WRITE.
//  - IDLE: cyc_en & cpu_wen & cpu_addr==DMA_REG_ADDR -> page<=cpu_data, idx<=0, go HALT.
//    Other addresses ($4015, $4013, ...) are ignored.
//  - HALT: rdy=0, bus_sel=0; the CPU still finishes pending write cycles.
//    Stay while cyc_en & cpu_wen.
//    On cyc_en & !cpu_wen: next state READ if the next cycle is a get (get_cyc==0 now), else ALIGN.
//  - ALIGN: rdy=0, bus_sel=1, no strobes; lasts one CPU cycle, then READ.
//  - READ: rdy=0, bus_sel=1, dma_ren=1, dma_addr={page,idx}.
//    On cyc_en, mem_rdata is latched into dma_wdata, then WRITE.
//  - WRITE: rdy=0, bus_sel=1, dma_wen=1, dma_addr=OAM_DATA_ADDR.
//    On cyc_en: if idx==XFER_LEN-1 -> IDLE, else idx<=idx+1 and READ.
//  - Outputs are Moore decodes of registered state; the strobes hold for the whole CPU cycle.
//  - Latency, trigger-write cycle to rdy=1: 1+2*XFER_LEN CPU cycles (513), or 514 with ALIGN.
//    Each CPU write cycle seen in HALT adds one cycle.
//  - rdy returns to 1 on the same edge that enters IDLE; bus_sel=0 on that edge.
//  - idx does not wrap inside a transfer; a page of $FF reads $FF00..$FFFF.
//  - CPU bus inputs are ignored outside IDLE, so a $4014 write during DMA is dropped.
//  - Reset mid-transfer: outputs return to their reset values asynchronously.
//    No partial write is completed; the OAM copy is left partially written.
// CONFIGURATION
//  OAM_DMA_HOLD_EN defined:
//  - Adds input dma_hold (1 bit), reserved for DMC-sample arbitration.
//  - dma_hold=1 at a cyc_en in READ or WRITE freezes state, idx and latch.
//    bus_sel and rdy keep their values; dma_ren and dma_wen are forced to 0 while held.
//  - get_cyc keeps toggling.
//  - Resume must re-align: from READ, if the next cycle is a put, spend one ALIGN cycle first.
//  - dma_hold is ignored in IDLE, HALT and ALIGN.
//  OAM_DMA_HOLD_EN undefined: port absent; behaviour exactly as above.
// TESTING
//  1. Write $4014<=8'h02 with the next cycle a get; memory $0200+i = i^8'hA5.
//     -> 256 reads $0200..$02FF, 256 writes to $2004 of i^A5 in order; rdy low exactly 513 cycles.
//  2. Same trigger with the next cycle a put.
//     -> one ALIGN cycle with no strobes; rdy low 514 cycles; first read on a get cycle.
//  3. Trigger, then the CPU performs 2 more write cycles.
//     -> HALT lasts 3 cycles; total 515/516; no DMA strobes while cpu_wen=1.
//  4. Assert rst low while idx==8'h40 in WRITE.
//     -> rdy=1, bus_sel=0, dma_wen=0 immediately; after release, write $4015 -> stays IDLE.
//  5. Page $FF, XFER_LEN=256.
//     -> last read at $FFFF, last write data = mem[$FFFF]; then IDLE, no access to $0000.
//  6. (OAM_DMA_HOLD_EN) dma_hold=1 for 3 cycles during READ idx=8'h10.
//     -> no strobes for 3 cycles, read of $xx10 resumes on a get cycle.
//     -> data is unchanged; total latency grows by 3 or 4.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: snoops the $4014 write, halts the CPU, then copies one page into OAM.
// Optional OAM_DMA_HOLD_EN adds dma_hold to pause the read/write stream.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wen,
  input  logic [7:0]  mem_rdata,
`ifdef OAM_DMA_HOLD_EN
  input  logic        dma_hold,
`endif
  output logic        rdy,
  output logic        bus_sel,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        dma_ren,
  output logic        dma_wen,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] wdata_q, wdata_d;
  logic       get_cyc_q, get_cyc_d;
  logic       hold;

`ifdef OAM_DMA_HOLD_EN
  assign hold = dma_hold & ((state_q == READ) | (state_q == WRITE));
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 8'h00;
      page_q    <= 8'h00;
      wdata_q   <= 8'h00;
      get_cyc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      page_q    <= page_d;
      wdata_q   <= wdata_d;
      get_cyc_q <= get_cyc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    page_d    = page_q;
    wdata_d   = wdata_q;
    get_cyc_d = cyc_en ? ~get_cyc_q : get_cyc_q;
    if (cyc_en) begin
      case (state_q)
        IDLE: begin
          if (cpu_wen && (cpu_addr == DMA_REG_ADDR)) begin
            page_d  = cpu_data;
            idx_d   = 8'h00;
            state_d = HALT;
          end
        end
        HALT: begin
          // get_cyc_q=1 now means the next cycle is a put, so burn one ALIGN cycle
          if (!cpu_wen) state_d = get_cyc_q ? ALIGN : READ;
        end
        ALIGN: state_d = READ;
        READ: begin
          if (hold) begin
            if (get_cyc_q) state_d = ALIGN;
          end else begin
            wdata_d = mem_rdata;
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (!hold) begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
            end else begin
              idx_d   = idx_q + 8'd1;
              // A held WRITE can end on a get cycle; reads must stay on get cycles
              state_d = get_cyc_q ? ALIGN : READ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rdy       = (state_q == IDLE);
    busy      = (state_q != IDLE);
    bus_sel   = (state_q == ALIGN) | (state_q == READ) | (state_q == WRITE);
    dma_ren   = (state_q == READ) & ~hold;
    dma_wen   = (state_q == WRITE) & ~hold;
    dma_wdata = wdata_q;
    dma_addr  = 16'h0000;
    if (state_q == READ)  dma_addr = {page_q, idx_q};
    if (state_q == WRITE) dma_addr = OAM_DATA_ADDR;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: full transfers with/without ALIGN, CPU write stalls, page $FF, mid-transfer reset.
module tb_oam_dma_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wen;
  logic [7:0]  mem_rdata;
  logic        rdy, bus_sel, dma_ren, dma_wen, busy;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;

  int n_err = 0;
  int n_chk = 0;
  int ncyc  = 0;

  always #5 clk = ~clk;

  // Memory image: byte at $xxNN reads NN^A5; nothing is returned without a read strobe
  assign mem_rdata = dma_ren ? (dma_addr[7:0] ^ 8'hA5) : 8'h00;

  oam_dma_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cyc_en    (cyc_en),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_wen   (cpu_wen),
    .mem_rdata (mem_rdata),
    .rdy       (rdy),
    .bus_sel   (bus_sel),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ren   (dma_ren),
    .dma_wen   (dma_wen),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU cycle = two clks, the second carrying cyc_en; returns mid-cycle for sampling
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(negedge clk);
    cyc_en   = 1'b0;
    cpu_addr = a;
    cpu_data = d;
    cpu_wen  = w;
    @(negedge clk);
    cyc_en = 1'b1;
    ncyc++;
  endtask

  task automatic sync_parity(input int p);
    while ((ncyc % 2) != p) cyc(16'h0000, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    cyc_en = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    ncyc = 0;
  endtask

  task automatic do_xfer(input logic [7:0] pg, input int nwr, input bit exp_align,
                         input int exp_low, input int abort_idx);
    int low;
    logic [7:0] ib;
    low = 0;
    cyc(16'h4014, pg, 1'b1);
    chk("trig_rdy", {rdy, busy}, 2'b10);
    for (int w = 0; w < nwr; w++) begin
      cyc(16'h0100 + 16'(w), 8'h55, 1'b1);
      low++;
      chk("halt_wr", {rdy, bus_sel, dma_ren, dma_wen, busy}, 5'b00001);
    end
    cyc(16'h0000, 8'h00, 1'b0);
    low++;
    chk("halt_rd", {rdy, bus_sel, dma_ren, dma_wen, busy}, 5'b00001);
    if (exp_align) begin
      cyc(16'h0000, 8'h00, 1'b0);
      low++;
      chk("align", {rdy, bus_sel, dma_ren, dma_wen}, 4'b0100);
    end
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      // Stray $4014 writes while busy must be ignored
      cyc(16'h4014, 8'h33, 1'b1);
      low++;
      chk("read", {rdy, bus_sel, dma_ren, dma_wen, dma_addr}, {4'b0110, pg, ib});
      cyc(16'h4014, 8'h44, 1'b1);
      low++;
      chk("write", {rdy, bus_sel, dma_ren, dma_wen, dma_addr, dma_wdata},
          {4'b0101, 16'h2004, ib ^ 8'hA5});
      if (i == abort_idx) begin
        rst    = 1'b0;
        cyc_en = 1'b0;
        #1;
        chk("rst_async", {rdy, bus_sel, dma_ren, dma_wen, busy, dma_addr, dma_wdata},
            {5'b10000, 16'h0000, 8'h00});
        return;
      end
    end
    cyc(16'h0000, 8'h00, 1'b0);
    chk("done", {rdy, bus_sel, dma_ren, dma_wen, busy}, 5'b10000);
    chk("rdy_low_cycles", 64'(low), 64'(exp_low));
  endtask

  initial begin
    rst      = 1'b0;
    cyc_en   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    cpu_wen  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",     rdy,       1'b1);
    chk("rst_bus_sel", bus_sel,   1'b0);
    chk("rst_ren",     dma_ren,   1'b0);
    chk("rst_wen",     dma_wen,   1'b0);
    chk("rst_busy",    busy,      1'b0);
    chk("rst_addr",    dma_addr,  16'h0000);
    chk("rst_wdata",   dma_wdata, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Non-trigger traffic in IDLE
    cyc(16'h4015, 8'h02, 1'b1);
    cyc(16'h4014, 8'h02, 1'b0);
    cyc(16'h0000, 8'h00, 1'b0);
    chk("idle_ignore", {rdy, busy, bus_sel}, 3'b100);

    // Next cycle after HALT is a get: no ALIGN
    sync_parity(1);
    do_xfer(8'h02, 0, 1'b0, 513, -1);

    // Next cycle after HALT is a put: one ALIGN
    sync_parity(0);
    do_xfer(8'h02, 0, 1'b1, 514, -1);

    // Two extra CPU writes stretch HALT
    sync_parity(1);
    do_xfer(8'h02, 2, 1'b0, 515, -1);

    // Top page, ends at $FFFF without wrapping
    sync_parity(0);
    do_xfer(8'hFF, 0, 1'b1, 514, -1);

    // Reset while writing idx $40
    sync_parity(1);
    do_xfer(8'h02, 0, 1'b0, 0, 64);
    @(negedge clk);
    rst  = 1'b1;
    ncyc = 0;
    cyc(16'h4015, 8'h12, 1'b1);
    cyc(16'h4013, 8'h34, 1'b1);
    cyc(16'h0000, 8'h00, 1'b0);
    chk("post_rst_idle", {rdy, busy, bus_sel, dma_ren, dma_wen}, 5'b10000);

    // A fresh transfer still works after the abort
    sync_parity(1);
    do_xfer(8'h03, 0, 1'b0, 513, -1);

    do_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
